// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start from the
// requester, busy/done and the registered result back to it.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, difference, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, difference, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one shared half-subtractor pair processes a - b LSB-first,
// one bit per clock, with the borrow carried between cycles in a flop.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic br
);
    assign d  = x ^ y;
    assign br = ~x & y;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt_r;
    logic             br_r;
    logic             borrow_r;
    logic             busy_r;
    logic             done_r;

    logic d1_s;
    logic br1_s;
    logic d_s;
    logic br2_s;
    logic br_next_s;
    logic last_bit_s;

    half_subtractor u_hs1 (.x(a_sh_r[0]), .y(b_sh_r[0]), .d(d1_s), .br(br1_s));
    half_subtractor u_hs2 (.x(d1_s),      .y(br_r),      .d(d_s),  .br(br2_s));

    assign br_next_s  = br1_s | br2_s;
    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

    // Sequencer: accepts a request, steps the serial stage, and holds the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            diff_r   <= '0;
            cnt_r    <= '0;
            br_r     <= 1'b0;
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_r   <= bus.a;
                        b_sh_r   <= bus.b;
                        diff_r   <= '0;
                        cnt_r    <= '0;
                        br_r     <= 1'b0;
                        borrow_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                    done_r <= 1'b0;
                end
                RUN: begin
                    // The difference register fills from the top so bit 0 ends at position 0.
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    diff_r <= {d_s, diff_r[WIDTH-1:1]};
                    br_r   <= br_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        borrow_r <= br_next_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        state_r  <= RUN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.difference = diff_r;
    assign bus.borrow_out = borrow_r;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of the bit-serial subtractor controller at WIDTH=8.
module tb_serial_subtractor_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    serial_subtractor_ctrl_if #(.WIDTH(8)) bus ();

    serial_subtractor_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check busy length, result, done pulse and hold.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv);
        logic [8:0] full;
        int busy_cnt;
        int guard;
        full = {1'b0, av} - {1'b0, bv};
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        tick();
        bus.start = 1'b0;
        bus.a = ~av;
        bus.b = 8'($urandom);
        busy_cnt = 0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            guard++;
        end
        check("done_timeout", 32'(guard < 20), 32'd1);
        check("busy_len", 32'(busy_cnt), 32'd8);
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
        check("difference", 32'(bus.difference), 32'(full[7:0]));
        check("borrow_out", 32'(bus.borrow_out), 32'(av < bv));
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("hold_difference", 32'(bus.difference), 32'(full[7:0]));
        check("hold_borrow", 32'(bus.borrow_out), 32'(av < bv));
    endtask

    initial begin
        int done_cnt;
        int busy_seen;
        int t;
        int d1;
        int d2;
        int guard;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.difference), 32'd0);
        check("rst_borrow", 32'(bus.borrow_out), 32'd0);

        // 1-3: basic, borrow/wrap, equal and zero
        do_op(8'h5A, 8'h23);
        tick();
        check("idle_hold_5a", 32'(bus.difference), 32'h37);
        do_op(8'h10, 8'h20);
        do_op(8'h00, 8'h01);
        do_op(8'hFF, 8'hFF);
        do_op(8'h00, 8'h00);

        // 4: start pulses during RUN and DONE are ignored
        bus.start = 1'b1;
        bus.a = 8'h80;
        bus.b = 8'h01;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h22;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("ign_timeout", 32'(guard < 20), 32'd1);
        check("ign_diff", 32'(bus.difference), 32'h7F);
        check("ign_borrow", 32'(bus.borrow_out), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cnt = 0;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy === 1'b1) busy_seen++;
            tick();
        end
        check("ign_no_second_done", 32'(done_cnt), 32'd0);
        check("ign_no_second_busy", 32'(busy_seen), 32'd0);
        check("ign_hold_diff", 32'(bus.difference), 32'h7F);

        // 5: reset in the middle of an operation
        bus.start = 1'b1;
        bus.a = 8'hC3;
        bus.b = 8'h3C;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_diff", 32'(bus.difference), 32'd0);
        check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        do_op(8'h01, 8'h02);

        // 6a: start held high issues every WIDTH+2 cycles
        bus.start = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        d1 = -1;
        d2 = -1;
        done_cnt = 0;
        for (t = 1; t <= 25; t++) begin
            tick();
            if (bus.done === 1'b1) begin
                done_cnt++;
                check("b2b_diff", 32'(bus.difference), 32'h22);
                check("b2b_not_busy", 32'(bus.busy), 32'd0);
                if (d1 < 0) d1 = t;
                else if (d2 < 0) d2 = t;
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        check("b2b_interval", 32'(d2 - d1), 32'd10);
        for (int i = 0; i < 12; i++) tick();

        // 6b: random operand pairs
        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end
endmodule
